// File: rtl/sub_issue_stage_if.sv
// -----------------------------------------------------------------------------
// sub_issue_stage_if
// Handshake bundle between the operand producer / result consumer and the
// subtractor issue stage.
//   in_valid/in_ready/in_a/in_b    : operand pair handshake (producer -> stage)
//   out_valid/out_ready            : result handshake (stage -> consumer)
//   out_diff/out_borrow/out_zero/out_ovf : FIFO head contents
// modport master : producer/consumer side (testbench or upstream logic)
// modport slave  : the issue stage itself
// -----------------------------------------------------------------------------
interface sub_issue_stage_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_diff;
  logic       out_borrow;
  logic       out_zero;
  logic       out_ovf;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_diff, out_borrow, out_zero, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_diff, out_borrow, out_zero, out_ovf
  );
endinterface

// File: rtl/sub_issue_stage.sv
// -----------------------------------------------------------------------------
// sub_issue_stage
// Issues operand pairs to an external combinational 4-bit subtractor, holds
// them for one evaluation cycle, captures the difference, derives borrow /
// zero / overflow flags and queues the result in a 2-entry FIFO.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   bus        : operand and result handshakes (slave side)
//   sub_bit1   : minuend driven to the subtractor
//   sub_bit2   : subtrahend driven to the subtractor
//   sub_answer : subtractor result; bit 4 is not used
//   ops_done   : results pushed into the FIFO, modulo 256
// -----------------------------------------------------------------------------
module sub_issue_stage (
  input  logic               clk,
  input  logic               rst,
  sub_issue_stage_if.slave   bus,
  output logic [3:0]         sub_bit1,
  output logic [3:0]         sub_bit2,
  input  logic [4:0]         sub_answer,
  output logic [7:0]         ops_done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EVAL = 1'b1;

  typedef struct packed {
    logic [3:0] diff;
    logic       borrow;
    logic       zero;
    logic       ovf;
  } entry_t;

  logic [0:0] state;
  logic [3:0] op_a;
  logic [3:0] op_b;
  entry_t     fifo_mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] fifo_count;
  entry_t     new_entry;
  entry_t     head;
  logic       accept;
  logic       push;
  logic       pop;

  // The borrow-out is recomputed from the latched operands instead.
  logic unused_answer_msb;
  assign unused_answer_msb = sub_answer[4];

  // in_ready depends only on state and occupancy, never on in_valid, so the
  // producer can safely derive in_valid from in_ready without a loop.
  assign bus.in_ready  = !rst && (state == IDLE) && (fifo_count < 2'd2);
  assign accept        = bus.in_valid && bus.in_ready;
  assign push          = (state == EVAL);
  assign bus.out_valid = (fifo_count != 2'd0);
  assign pop           = bus.out_valid && bus.out_ready;

  assign sub_bit1 = op_a;
  assign sub_bit2 = op_b;

  // NOTE: every field gets a default first so no path through the block
  // leaves a value held, which would otherwise infer a latch.
  always_comb begin
    new_entry        = '0;
    new_entry.diff   = sub_answer[3:0];
    new_entry.borrow = (op_a < op_b);
    new_entry.zero   = (sub_answer[3:0] == 4'd0);
    // Signed overflow: operands of opposite sign and the result's sign
    // differs from the minuend's.
    new_entry.ovf    = (op_a[3] != op_b[3]) && (sub_answer[3] != op_a[3]);
  end

  assign head           = fifo_mem[rd_ptr];
  assign bus.out_diff   = head.diff;
  assign bus.out_borrow = head.borrow;
  assign bus.out_zero   = head.zero;
  assign bus.out_ovf    = head.ovf;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_a       <= 4'd0;
      op_b       <= 4'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      ops_done   <= 8'd0;
      // NOTE: the two storage entries are cleared because the head entry is
      // visible on the outputs and must read as zero straight out of reset.
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a  <= bus.in_a;
            op_b  <= bus.in_b;
            state <= EVAL;
          end
        end
        default: state <= IDLE;
      endcase

      // Accepts are gated on fifo_count < 2, so a push never finds it full.
      if (push) begin
        fifo_mem[wr_ptr] <= new_entry;
        wr_ptr           <= ~wr_ptr;
        ops_done         <= ops_done + 8'd1;
      end

      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_sub_issue_stage
// Self-checking bench for sub_issue_stage. A behavioural subtractor drives
// sub_answer; a negedge scoreboard follows every handshake and compares each
// visible FIFO head and ops_done against an arithmetic model. Directed
// sequences and a vector table cover the flag cases, backpressure, streaming,
// mid-operation reset and counter wrap.
// -----------------------------------------------------------------------------
module tb_sub_issue_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sub_bit1;
  logic [3:0] sub_bit2;
  logic [4:0] sub_answer;
  logic [7:0] ops_done;

  always #5 clk = ~clk;

  sub_issue_stage_if bus ();

  // Behavioural subtractor, settles within the cycle.
  assign sub_answer = {1'b0, sub_bit1} - {1'b0, sub_bit2};

  sub_issue_stage dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sub_bit1   (sub_bit1),
    .sub_bit2   (sub_bit2),
    .sub_answer (sub_answer),
    .ops_done   (ops_done)
  );

  int n_vec  = 0;
  int n_err  = 0;
  int n_pops = 0;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result {diff, borrow, zero, ovf} from integer arithmetic.
  function automatic logic [6:0] ref_result(input logic [3:0] a, input logic [3:0] b);
    int ia, ib, sa, sb, sd, dm;
    logic [3:0] d;
    ia = int'(a);
    ib = int'(b);
    dm = (ia - ib + 16) % 16;
    d  = dm[3:0];
    sa = (ia > 7) ? ia - 16 : ia;
    sb = (ib > 7) ? ib - 16 : ib;
    sd = sa - sb;
    return {d, (ia < ib), (dm == 0), ((sd < -8) || (sd > 7))};
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard: runs on the falling edge, where inputs (driven 1 ns after the
  // rising edge) and outputs are both stable.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
  } op_t;

  op_t model_q[$];
  int  exp_ops   = 0;
  bit  eval_flag = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      check("in_ready_during_reset", 32'(bus.in_ready), 32'd0);
      model_q.delete();
      exp_ops   = 0;
      eval_flag = 1'b0;
    end else begin
      check("ops_done", 32'(ops_done), 32'(exp_ops));
      if (bus.out_valid) begin
        if (model_q.size() == 0) begin
          check("spurious_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          check("head_result",
                32'({bus.out_diff, bus.out_borrow, bus.out_zero, bus.out_ovf}),
                32'(ref_result(model_q[0].a, model_q[0].b)));
          if (bus.out_ready) begin
            void'(model_q.pop_front());
            n_pops++;
          end
        end
      end
      if (eval_flag) begin
        check("in_ready_after_accept", 32'(bus.in_ready), 32'd0);
        exp_ops = (exp_ops + 1) % 256;
      end
      eval_flag = bus.in_valid && bus.in_ready;
      if (eval_flag) begin
        model_q.push_back('{bus.in_a, bus.in_b});
        check("outstanding_le_2", 32'(model_q.size() <= 2), 32'd1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_ready(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (bus.in_ready) return;
      tick();
    end
    check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  // Returns one cycle after the accepting edge, i.e. during EVAL.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b);
    wait_ready(50);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] diff;
    logic       borrow;
    logic       zero;
    logic       ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int p;
    int pops_before;

    vecs[0] = '{4'd9,  4'd3,  4'd6,  1'b0, 1'b0, 1'b1};
    vecs[1] = '{4'd3,  4'd9,  4'd10, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{4'd5,  4'd5,  4'd0,  1'b0, 1'b1, 1'b0};
    vecs[3] = '{4'd0,  4'd1,  4'd15, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{4'd8,  4'd1,  4'd7,  1'b0, 1'b0, 1'b1};
    vecs[5] = '{4'd7,  4'd15, 4'd8,  1'b1, 1'b0, 1'b1};
    vecs[6] = '{4'd12, 4'd4,  4'd8,  1'b0, 1'b0, 1'b0};
    vecs[7] = '{4'd15, 4'd15, 4'd0,  1'b0, 1'b1, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_a      = 4'd0;
    bus.in_b      = 4'd0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    tick();
    tick();

    // Reset state.
    check("rst_in_ready",   32'(bus.in_ready),   32'd0);
    check("rst_out_valid",  32'(bus.out_valid),  32'd0);
    check("rst_out_diff",   32'(bus.out_diff),   32'd0);
    check("rst_out_flags",  32'({bus.out_borrow, bus.out_zero, bus.out_ovf}), 32'd0);
    check("rst_sub_bits",   32'({sub_bit1, sub_bit2}), 32'd0);
    check("rst_ops_done",   32'(ops_done),       32'd0);
    rst = 1'b0;

    // Vector table: latency and flags for each pair.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b);
      check("vec_eval_no_valid", 32'(bus.out_valid), 32'd0);
      check("vec_sub_bits", 32'({sub_bit1, sub_bit2}), 32'({vecs[i].a, vecs[i].b}));
      tick();
      check("vec_out_valid", 32'(bus.out_valid), 32'd1);
      check("vec_diff",   32'(bus.out_diff),   32'(vecs[i].diff));
      check("vec_borrow", 32'(bus.out_borrow), 32'(vecs[i].borrow));
      check("vec_zero",   32'(bus.out_zero),   32'(vecs[i].zero));
      check("vec_ovf",    32'(bus.out_ovf),    32'(vecs[i].ovf));
      check("vec_ops_done", 32'(ops_done), 32'(i + 1));
    end
    tick();
    tick();

    // Backpressure: two pairs fit, the third waits for a pop.
    bus.out_ready = 1'b0;
    bus.in_a      = 4'd1;
    bus.in_b      = 4'd0;
    bus.in_valid  = 1'b1;
    acc = 0;
    p   = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.in_ready) begin
        acc++;
        tick();
        p++;
        bus.in_a = 4'(p + 1);
      end else begin
        tick();
      end
    end
    check("bp_accepts", 32'(acc), 32'd2);
    check("bp_in_ready_held", 32'(bus.in_ready), 32'd0);
    check("bp_head_first", 32'(bus.out_diff), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    check("bp_ready_after_pop", 32'(bus.in_ready), 32'd1);
    check("bp_head_second", 32'(bus.out_diff), 32'd2);
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("bp_third_valid", 32'(bus.out_valid), 32'd1);
    check("bp_head_third", 32'(bus.out_diff), 32'd3);
    tick();
    tick();

    // Simultaneous push/pop: one entry queued, then stream six pairs.
    bus.out_ready = 1'b0;
    do_op(4'd4, 4'd1);
    tick();
    pops_before   = n_pops;
    bus.out_ready = 1'b1;
    p             = 0;
    bus.in_a      = 4'($urandom_range(0, 15));
    bus.in_b      = 4'($urandom_range(0, 15));
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 40 && p < 6; c++) begin
      if (bus.in_ready) begin
        tick();
        p++;
        bus.in_a = 4'($urandom_range(0, 15));
        bus.in_b = 4'($urandom_range(0, 15));
      end else begin
        tick();
      end
    end
    bus.in_valid = 1'b0;
    repeat (4) tick();
    check("stream_pop_count", 32'(n_pops - pops_before), 32'd7);

    // Reset during EVAL with one result queued.
    bus.out_ready = 1'b0;
    do_op(4'd7, 4'd2);
    tick();
    do_op(4'd6, 4'd6);
    rst = 1'b1;
    tick();
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_ops_done",  32'(ops_done),      32'd0);
    check("mid_rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("mid_rst_sub_bits",  32'({sub_bit1, sub_bit2}), 32'd0);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("post_rst_no_stale", 32'(bus.out_valid), 32'd0);
    end

    // Random operands and consumer stalls, 256 operations for the wrap.
    rand_ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    tick();
    check("wrap_ops_255", 32'(ops_done), 32'd255);
    do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    tick();
    check("wrap_ops_0", 32'(ops_done), 32'd0);
    rand_ready    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) tick();
    check("final_drained", 32'(bus.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sub_issue_stage.md
# sub_issue_stage

Operand issue and result capture stage for the 4-bit subtractor datapath. It accepts operand pairs over a valid/ready handshake and holds them stable on the subtractor inputs for one evaluation cycle. It then captures the subtractor's 4-bit difference, derives status flags locally, and queues each result in a 2-entry output FIFO for the downstream consumer. It sits directly upstream of the subtractor, driving its inputs, and also consumes its output.

## Interface
- Parameters: none; all widths are fixed.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operand pair present.
- `in_ready` output 1: stage accepts an operand pair this cycle.
- `in_a` input 4: minuend.
- `in_b` input 4: subtrahend.
- `sub_bit1` output 4: minuend driven to the subtractor.
- `sub_bit2` output 4: subtrahend driven to the subtractor.
- `sub_answer` input 5: subtractor result. Only bits [3:0] are used; bit 4 is ignored.
- `out_valid` output 1: FIFO head is valid.
- `out_ready` input 1: consumer takes the head.
- `out_diff` output 4: difference, a−b mod 16.
- `out_borrow` output 1: 1 when a<b (unsigned).
- `out_zero` output 1: 1 when diff==0.
- `out_ovf` output 1: two's-complement overflow.
- `ops_done` output 8: count of results pushed into the FIFO; wraps 255→0.

## Operation
- FSM has two states, IDLE and EVAL; reset enters IDLE.
- IDLE:
  - `in_ready` = (fifo_count < 2).
  - When `in_valid && in_ready`, load `in_a`/`in_b` into the operand registers and go to EVAL.
- EVAL:
  - `in_ready` = 0.
  - Operand registers drive `sub_bit1`/`sub_bit2` and have been stable since the preceding edge.
  - At the end of EVAL, push {`sub_answer[3:0]`, borrow, zero, ovf} into the FIFO, increment `ops_done`, and return to IDLE.
- Flags are computed from the latched operands and the captured diff:
  - borrow = (a < b) unsigned.
  - zero = (diff == 4'd0).
  - ovf = (a[3] != b[3]) && (diff[3] != a[3]).
- `sub_bit1`/`sub_bit2` hold the last operands until the next accept.
- FIFO:
  - 2 entries, first in, first out.
  - Pop when `out_valid && out_ready`.
  - Outputs show the head entry; content is don't-care when `out_valid`=0.
  - An accept in IDLE is allowed only if count<2, so the push at the end of EVAL never overflows.
  - Simultaneous push and pop: count unchanged, order preserved.
- `out_valid`, `out_diff` and the flags stay stable while `out_valid && !out_ready`.

## Timing
- Reset values when `rst`=1 at an edge:
  - state IDLE, FIFO empty.
  - `out_valid`=0, `out_diff`=0, all flags 0.
  - `sub_bit1`=`sub_bit2`=0, `ops_done`=0.
  - `in_ready`=0 while `rst` is asserted.
- Reset mid-operation, in EVAL or with the FIFO non-empty: the in-flight operation and all queued results are discarded, with no push and no `ops_done` increment.
- Latency:
  - Accept at edge N.
  - EVAL during cycle N→N+1.
  - Push at edge N+1; `out_valid`=1 in the cycle after edge N+1.
- Throughput: one operation per 2 cycles. `in_ready` is 0 in the cycle following each accept.
- The subtractor is combinational and must settle within one clock period. No extra wait state is needed.
- `in_ready` is a function only of state and fifo_count; it never depends combinationally on `in_valid`.

## Test plan
- **Basic:** reset, then a=9, b=3 with `out_ready`=1 → one cycle after the capture edge, `out_diff`=6, borrow=0, zero=0, ovf=1, `ops_done`=1.
- **Flags sweep:** (3,9) → diff=10, borrow=1, ovf=1. (5,5) → diff=0, zero=1, borrow=0, ovf=0. (0,1) → diff=15, borrow=1, ovf=0, zero=0.
- **Backpressure:** `out_ready`=0, `in_valid` held high with three pairs (1,0), (2,0), (3,0):
  - Two pairs are accepted, then `in_ready` stays 0.
  - Raise `out_ready` → diffs 1, 2, 3 appear in order.
  - The third pair is accepted only after the first pop.
- **Simultaneous push/pop:** with one entry queued and `out_ready`=1 continuously, stream 6 pairs → count never exceeds 2, results are in order, and outputs are never lost or duplicated.
- **Reset mid-operation:** assert `rst` during EVAL with one result queued → next cycle `out_valid`=0, `ops_done`=0, and no stale result appears after reset.
- **Counter wrap:** 256 operations → `ops_done` reads 0 after the 256th push.
